// File: rtl/cdc_rx_deframer_if.sv
// cdc_rx_deframer_if
//   Bundles the two streams around the deframer: the FIFO peek side
//   (InValid_DB / InData_DB / InDeq_DB) and the narrowed chunk stream
//   (OutValid_DB / OutReady_DB / OutData_DB / OutFirst_DB / OutLast_DB).
//   master : the deframer (consumes FIFO words, produces chunks)
//   slave  : the environment (FIFO plus downstream sink)
//   DataWidth / OutWidth must match the parameters of the deframer instance.
interface cdc_rx_deframer_if #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8
);
  logic                 InValid_DB;
  logic [DataWidth-1:0] InData_DB;
  logic                 InDeq_DB;
  logic                 OutValid_DB;
  logic                 OutReady_DB;
  logic [OutWidth-1:0]  OutData_DB;
  logic                 OutFirst_DB;
  logic                 OutLast_DB;

  modport master (
    input  InValid_DB, InData_DB, OutReady_DB,
    output InDeq_DB, OutValid_DB, OutData_DB, OutFirst_DB, OutLast_DB
  );

  modport slave (
    output InValid_DB, InData_DB, OutReady_DB,
    input  InDeq_DB, OutValid_DB, OutData_DB, OutFirst_DB, OutLast_DB
  );
endinterface

// File: rtl/cdc_rx_deframer.sv
// cdc_rx_deframer
//   Receiver-domain consumer of the CDC FIFO peek interface. Hunts for a header
//   word (magic in the upper bits, payload length in the lower LenWidth bits),
//   then splits each payload word into Ratio = DataWidth/OutWidth chunks, LSB
//   first, on a valid/ready stream with First/Last markers. Headers with a bad
//   magic or an oversize length are consumed and counted, so the receiver
//   resynchronises on its own.
// Ports
//   clk_DB          receiver-domain clock
//   rst_n           synchronous reset, active low
//   bus (master)    FIFO peek (InValid/InData/InDeq) and chunk stream
//                   (OutValid/OutReady/OutData/OutFirst/OutLast)
//   EmptyFrame_DB   one-cycle pulse after a valid header with length 0
//   FrameCount_DB   completed frames, wraps
//   BadHdrCount_DB  rejected headers, saturates at 16'hFFFF
module cdc_rx_deframer #(
  parameter int                            DataWidth   = 32,
  parameter int                            OutWidth    = 8,
  parameter int                            LenWidth    = 16,
  parameter logic [DataWidth-LenWidth-1:0] HeaderMagic = 16'hA5A5,
  parameter int                            MaxLen      = 1024
) (
  input  logic                   clk_DB,
  input  logic                   rst_n,
  cdc_rx_deframer_if.master      bus,
  output logic                   EmptyFrame_DB,
  output logic [15:0]            FrameCount_DB,
  output logic [15:0]            BadHdrCount_DB
);

  localparam int Ratio = DataWidth / OutWidth;
  localparam int CIW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CIW-1:0] LastIdx = CIW'(Ratio - 1);

  typedef enum logic [1:0] {HDR, LOAD, EMIT} state_t;

  state_t                state, stateNext;
  logic [DataWidth-1:0]  wordBuf, wordBufNext;
  logic [CIW-1:0]        chunkIdx, chunkIdxNext;
  logic [LenWidth-1:0]   remaining, remainingNext;
  logic                  firstFlag, firstFlagNext;
  logic                  emptyFrame, emptyFrameNext;
  logic [15:0]           frameCount, frameCountNext;
  logic [15:0]           badHdrCount, badHdrCountNext;

  logic [DataWidth-LenWidth-1:0] hdrMagic;
  logic [LenWidth-1:0]           hdrLen;
  logic [OutWidth-1:0]           chunkData;
  logic                          inDeq, outValid, outFirst, outLast;
  logic [OutWidth-1:0]           outData;

  assign hdrMagic = bus.InData_DB[DataWidth-1:LenWidth];
  assign hdrLen   = bus.InData_DB[LenWidth-1:0];

  // Chunk mux over the buffered word; a constant-index loop keeps the part
  // select widths exact.
  always_comb begin
    chunkData = '0;
    for (int i = 0; i < Ratio; i++) begin
      if (chunkIdx == i[CIW-1:0]) chunkData = wordBuf[i*OutWidth +: OutWidth];
    end
  end

  always_comb begin
    stateNext       = state;
    wordBufNext     = wordBuf;
    chunkIdxNext    = chunkIdx;
    remainingNext   = remaining;
    firstFlagNext   = firstFlag;
    emptyFrameNext  = 1'b0;
    frameCountNext  = frameCount;
    badHdrCountNext = badHdrCount;
    inDeq           = 1'b0;
    outValid        = 1'b0;
    outData         = '0;
    outFirst        = 1'b0;
    outLast         = 1'b0;

    case (state)
      HDR: begin
        if (bus.InValid_DB) begin
          inDeq = 1'b1;
          if (hdrMagic == HeaderMagic && hdrLen != '0 &&
              hdrLen <= LenWidth'(MaxLen)) begin
            remainingNext = hdrLen;
            firstFlagNext = 1'b1;
            stateNext     = LOAD;
          end else if (hdrMagic == HeaderMagic && hdrLen == '0) begin
            emptyFrameNext = 1'b1;
          end else if (badHdrCount != 16'hFFFF) begin
            badHdrCountNext = badHdrCount + 16'd1;
          end
        end
      end

      LOAD: begin
        if (bus.InValid_DB) begin
          inDeq         = 1'b1;
          wordBufNext   = bus.InData_DB;
          chunkIdxNext  = '0;
          remainingNext = remaining - LenWidth'(1);
          stateNext     = EMIT;
        end
      end

      EMIT: begin
        outValid = 1'b1;
        outData  = chunkData;
        outFirst = firstFlag && (chunkIdx == '0);
        outLast  = (remaining == '0) && (chunkIdx == LastIdx);
        if (bus.OutReady_DB) begin
          firstFlagNext = 1'b0;
          if (chunkIdx != LastIdx) begin
            chunkIdxNext = chunkIdx + CIW'(1);
          end else if (remaining == '0) begin
            frameCountNext = frameCount + 16'd1;
            stateNext      = HDR;
          end else if (bus.InValid_DB) begin
            // Reload on the last chunk's transfer so words stream back to back.
            inDeq         = 1'b1;
            wordBufNext   = bus.InData_DB;
            chunkIdxNext  = '0;
            remainingNext = remaining - LenWidth'(1);
          end else begin
            stateNext = LOAD;
          end
        end
      end

      default: stateNext = HDR;
    endcase
  end

  always_ff @(posedge clk_DB) begin
    if (!rst_n) begin
      state       <= HDR;
      wordBuf     <= '0;
      chunkIdx    <= '0;
      remaining   <= '0;
      firstFlag   <= 1'b0;
      emptyFrame  <= 1'b0;
      frameCount  <= '0;
      badHdrCount <= '0;
    end else begin
      state       <= stateNext;
      wordBuf     <= wordBufNext;
      chunkIdx    <= chunkIdxNext;
      remaining   <= remainingNext;
      firstFlag   <= firstFlagNext;
      emptyFrame  <= emptyFrameNext;
      frameCount  <= frameCountNext;
      badHdrCount <= badHdrCountNext;
    end
  end

  assign bus.InDeq_DB    = inDeq;
  assign bus.OutValid_DB = outValid;
  assign bus.OutData_DB  = outData;
  assign bus.OutFirst_DB = outFirst;
  assign bus.OutLast_DB  = outLast;
  assign EmptyFrame_DB   = emptyFrame;
  assign FrameCount_DB   = frameCount;
  assign BadHdrCount_DB  = badHdrCount;

endmodule

// File: tb/tb_cdc_rx_deframer.sv
// tb_cdc_rx_deframer
//   Directed bench for cdc_rx_deframer with default parameters. A queue models
//   the FIFO peek side; the chunk stream is logged per cycle and compared with
//   hand-computed frames.
module tb_cdc_rx_deframer;

  logic        clk_DB;
  logic        rst_n;
  logic        EmptyFrame_DB;
  logic [15:0] FrameCount_DB;
  logic [15:0] BadHdrCount_DB;

  cdc_rx_deframer_if #(.DataWidth(32), .OutWidth(8)) bus ();

  cdc_rx_deframer dut (
    .clk_DB         (clk_DB),
    .rst_n          (rst_n),
    .bus            (bus),
    .EmptyFrame_DB  (EmptyFrame_DB),
    .FrameCount_DB  (FrameCount_DB),
    .BadHdrCount_DB (BadHdrCount_DB)
  );

  initial clk_DB = 1'b0;
  always #5 clk_DB = ~clk_DB;

  logic [31:0] fifo [$];
  logic [7:0]  chunkQ [$];
  logic        firstQ [$];
  logic        lastQ [$];
  int          chunkCyc [$];
  int          deqCyc [$];

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int readyMode = 0;   // 0: always ready, 1: toggle, 2: never ready
  int zeroErr = 0, deqErr = 0, stallDeqErr = 0, stableErr = 0, stallCnt = 0, efCnt = 0;
  logic       holdPend = 1'b0;
  logic [7:0] holdData = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // While the FIFO is empty, InData carries a word that would look like a
  // valid header, so any sampling of it without InValid shows up.
  task automatic driveIn();
    bus.InValid_DB = (fifo.size() > 0);
    bus.InData_DB  = (fifo.size() > 0) ? fifo[0] : 32'hA5A5_0001;
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    driveIn();
  endtask

  task automatic clearLog();
    chunkQ.delete(); firstQ.delete(); lastQ.delete();
    chunkCyc.delete(); deqCyc.delete();
    efCnt = 0; stallCnt = 0;
  endtask

  task automatic cycle();
    logic deq;
    @(negedge clk_DB);
    if (bus.OutValid_DB && bus.OutReady_DB) begin
      chunkQ.push_back(bus.OutData_DB);
      firstQ.push_back(bus.OutFirst_DB);
      lastQ.push_back(bus.OutLast_DB);
      chunkCyc.push_back(cyc);
    end
    if (!bus.OutValid_DB && bus.OutData_DB != 8'h00) zeroErr++;
    if (holdPend && bus.OutData_DB != holdData) stableErr++;
    holdPend = bus.OutValid_DB && !bus.OutReady_DB;
    holdData = bus.OutData_DB;
    if (holdPend) begin
      stallCnt++;
      if (bus.InDeq_DB) stallDeqErr++;
    end
    if (bus.InDeq_DB && !bus.InValid_DB) deqErr++;
    if (EmptyFrame_DB) efCnt++;
    deq = bus.InDeq_DB;
    if (deq) deqCyc.push_back(cyc);
    @(posedge clk_DB);
    #1;
    if (deq && fifo.size() > 0) void'(fifo.pop_front());
    driveIn();
    case (readyMode)
      0:       bus.OutReady_DB = 1'b1;
      1:       bus.OutReady_DB = ~bus.OutReady_DB;
      default: bus.OutReady_DB = 1'b0;
    endcase
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Compare the logged chunks against n bytes of exp, LSB first.
  task automatic checkChunks(input string tag, input int n, input logic [63:0] exp);
    chk({tag, " count"}, chunkQ.size(), n);
    for (int i = 0; i < n && i < chunkQ.size(); i++) begin
      chk({tag, " data"}, chunkQ[i], exp[i*8 +: 8]);
      chk({tag, " first/last"}, {firstQ[i], lastQ[i]}, {(i == 0), (i == n - 1)});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.OutReady_DB = 1'b1;
    driveIn();

    // Reset state
    run(3);
    chk("rst OutValid", bus.OutValid_DB, 0);
    chk("rst OutData", bus.OutData_DB, 0);
    chk("rst First/Last", {bus.OutFirst_DB, bus.OutLast_DB}, 0);
    chk("rst EmptyFrame", EmptyFrame_DB, 0);
    chk("rst FrameCount", FrameCount_DB, 0);
    chk("rst BadHdrCount", BadHdrCount_DB, 0);
    rst_n = 1'b1;
    run(2);

    // T1: two-word frame, sink always ready
    clearLog();
    push(32'hA5A5_0002); push(32'h4433_2211); push(32'h8877_6655);
    run(20);
    checkChunks("T1", 8, 64'h8877_6655_4433_2211);
    if (chunkCyc.size() == 8 && deqCyc.size() > 0) begin
      chk("T1 latency", chunkCyc[0] - deqCyc[0], 2);
      chk("T1 back-to-back", chunkCyc[7] - chunkCyc[0], 7);
    end else chk("T1 logged", chunkCyc.size(), 8);
    chk("T1 FrameCount", FrameCount_DB, 1);

    // T2: same frame, sink toggles ready every cycle
    clearLog();
    readyMode = 1;
    push(32'hA5A5_0002); push(32'h4433_2211); push(32'h8877_6655);
    run(40);
    readyMode = 0;
    run(1);
    checkChunks("T2", 8, 64'h8877_6655_4433_2211);
    chk("T2 stalled", (stallCnt > 0), 1);
    chk("T2 stable while stalled", stableErr, 0);
    chk("T2 no deq while stalled", stallDeqErr, 0);
    chk("T2 FrameCount", FrameCount_DB, 2);

    // T3: bad magic, oversize length, then a one-word frame
    clearLog();
    push(32'hDEAD_0001); push(32'hA5A5_0401); push(32'hA5A5_0001); push(32'hCAFE_BABE);
    run(20);
    chk("T3 BadHdrCount", BadHdrCount_DB, 2);
    checkChunks("T3", 4, 64'h0000_0000_CAFE_BABE);
    chk("T3 FrameCount", FrameCount_DB, 3);

    // T4: empty frame then a normal frame
    clearLog();
    push(32'hA5A5_0000);
    run(4);
    chk("T4 EmptyFrame pulse", efCnt, 1);
    chk("T4 no chunks", chunkQ.size(), 0);
    chk("T4 FrameCount held", FrameCount_DB, 3);
    push(32'hA5A5_0001); push(32'h0403_0201);
    run(15);
    checkChunks("T4", 4, 64'h0000_0000_0403_0201);
    chk("T4 FrameCount", FrameCount_DB, 4);

    // T5: reset after the second chunk of a two-word frame
    clearLog();
    push(32'hA5A5_0002); push(32'h4433_2211); push(32'h8877_6655);
    for (int i = 0; i < 30 && chunkQ.size() < 2; i++) cycle();
    chk("T5 reached chunk 2", chunkQ.size(), 2);
    rst_n = 1'b0;
    readyMode = 2;
    bus.OutReady_DB = 1'b0;
    cycle();
    rst_n = 1'b1;
    readyMode = 0;
    bus.OutReady_DB = 1'b1;
    chk("T5 OutValid after rst", bus.OutValid_DB, 0);
    chk("T5 OutData after rst", bus.OutData_DB, 0);
    chk("T5 FrameCount after rst", FrameCount_DB, 0);
    chk("T5 BadHdrCount after rst", BadHdrCount_DB, 0);
    run(5);
    chk("T5 leftover counted bad", BadHdrCount_DB, 1);
    clearLog();
    push(32'hA5A5_0001); push(32'h0D0C_0B0A);
    run(15);
    checkChunks("T5", 4, 64'h0000_0000_0D0C_0B0A);
    chk("T5 FrameCount", FrameCount_DB, 1);

    // T6: 0x10001 bad headers saturate the counter
    for (int i = 0; i < 32'h1_0001; i++) fifo.push_back(32'h0000_0000);
    driveIn();
    run(32'h1_0001 + 4);
    chk("T6 BadHdrCount saturated", BadHdrCount_DB, 32'h0000_FFFF);
    chk("T6 FIFO drained", fifo.size(), 0);

    chk("no deq without valid", deqErr, 0);
    chk("OutData zero when idle", zeroErr, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
